// File: rtl/monitor_pkg.sv
// Shared definitions for the active-device monitor interface:
// default device count, index width derivation and event encoding.
package monitor_pkg;

   localparam int N_DEV_DEFAULT = 8;

   localparam logic EV_ON  = 1'b1;
   localparam logic EV_OFF = 1'b0;

   // Index width for n devices; never narrower than one bit.
   function automatic int id_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requesting index
// found when searching upward from ptr, wrapping at N_DEV.
module rr_arbiter
   import monitor_pkg::*;
#(
   parameter int N_DEV = N_DEV_DEFAULT,
   parameter int ID_W  = id_width(N_DEV)
) (
   input  logic [N_DEV-1:0] req,
   input  logic [ID_W-1:0]  ptr,
   output logic             gnt_valid,
   output logic [ID_W-1:0]  gnt_idx
);

   int idx;

   // Walk offsets from farthest to nearest so the nearest request wins.
   always_comb begin
      gnt_valid = 1'b0;
      gnt_idx   = '0;
      idx       = 0;
      for (int off = N_DEV - 1; off >= 0; off--) begin
         idx = int'(ptr) + off;
         if (idx >= N_DEV) begin
            idx = idx - N_DEV;
         end
         if (req[idx]) begin
            gnt_valid = 1'b1;
            gnt_idx   = ID_W'(idx);
         end
      end
   end

endmodule

// File: rtl/device_event_encoder.sv
// Turns per-device on/off status lines into a serialised change/on_off event
// stream, one event per cycle, arbitrated round-robin across devices.
module device_event_encoder
   import monitor_pkg::*;
#(
   parameter int N_DEV = N_DEV_DEFAULT,
   parameter int ID_W  = id_width(N_DEV)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic [N_DEV-1:0] dev_status,
   output logic             change,
   output logic             on_off,
   output logic [ID_W-1:0]  dev_id,
   output logic             busy
);

   logic [N_DEV-1:0] reported_q, reported_d;
   logic [ID_W-1:0]  ptr_q, ptr_d;
   logic             change_q, change_d;
   logic             on_off_q, on_off_d;
   logic [ID_W-1:0]  dev_id_q, dev_id_d;

   logic [N_DEV-1:0] pending;
   logic             gnt_valid;
   logic [ID_W-1:0]  gnt_idx;

   // A device is pending whenever its live state differs from what the
   // monitor was last told; toggling back clears it with no event.
   assign pending = dev_status ^ reported_q;
   assign busy    = |pending;

   rr_arbiter #(
      .N_DEV (N_DEV),
      .ID_W  (ID_W)
   ) u_arb (
      .req       (pending),
      .ptr       (ptr_q),
      .gnt_valid (gnt_valid),
      .gnt_idx   (gnt_idx)
   );

   always_comb begin
      reported_d = reported_q;
      ptr_d      = ptr_q;
      change_d   = 1'b0;
      on_off_d   = EV_OFF;
      dev_id_d   = dev_id_q;
      if (enable && gnt_valid) begin
         change_d            = 1'b1;
         on_off_d            = dev_status[gnt_idx] ? EV_ON : EV_OFF;
         dev_id_d            = gnt_idx;
         reported_d[gnt_idx] = dev_status[gnt_idx];
         // Explicit wrap: N_DEV need not be a power of two.
         ptr_d = (gnt_idx == ID_W'(N_DEV - 1)) ? '0 : gnt_idx + ID_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         reported_q <= '0;
         ptr_q      <= '0;
         change_q   <= 1'b0;
         on_off_q   <= 1'b0;
         dev_id_q   <= '0;
      end else begin
         reported_q <= reported_d;
         ptr_q      <= ptr_d;
         change_q   <= change_d;
         on_off_q   <= on_off_d;
         dev_id_q   <= dev_id_d;
      end
   end

   assign change = change_q;
   assign on_off = on_off_q;
   assign dev_id = dev_id_q;

endmodule

// File: tb/tb_device_event_encoder.sv
// Directed table-driven bench for device_event_encoder with a small
// up/down counter standing in for the active-device monitor.
module tb_device_event_encoder;

   logic       clk;
   logic       rst;
   logic       enable;
   logic [7:0] dev_status;
   logic       change;
   logic       on_off;
   logic [2:0] dev_id;
   logic       busy;

   int n_vec;
   int n_err;
   int mon_cnt;

   typedef struct {
      logic       rst;
      logic       en;
      logic [7:0] st;
      logic       ch;
      logic       oo;
      logic [2:0] id;
      logic       bz;
      int         cnt;   // expected monitor count, -1 = not checked
   } vec_t;

   vec_t vq[$];

   device_event_encoder #(.N_DEV(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .dev_status (dev_status),
      .change     (change),
      .on_off     (on_off),
      .dev_id     (dev_id),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) mon_cnt <= 0;
      else if (change) mon_cnt <= on_off ? mon_cnt + 1 : mon_cnt - 1;
   end

   function automatic void add(input logic r, input logic e, input logic [7:0] s,
                               input logic c, input logic o, input logic [2:0] i,
                               input logic b, input int n);
      vec_t v;
      v.rst = r; v.en = e; v.st = s; v.ch = c; v.oo = o; v.id = i; v.bz = b; v.cnt = n;
      vq.push_back(v);
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic apply(input int k, input vec_t v);
      @(negedge clk);
      rst        = v.rst;
      enable     = v.en;
      dev_status = v.st;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d change", k), int'(change), int'(v.ch));
      chk($sformatf("v%0d on_off", k), int'(on_off), int'(v.oo));
      chk($sformatf("v%0d dev_id", k), int'(dev_id), int'(v.id));
      chk($sformatf("v%0d busy", k), int'(busy), int'(v.bz));
      if (v.cnt >= 0) chk($sformatf("v%0d monitor", k), mon_cnt, v.cnt);
   endtask

   initial begin
      n_vec      = 0;
      n_err      = 0;
      rst        = 1'b1;
      enable     = 1'b0;
      dev_status = 8'h00;

      // Reset, then quiet for 10 cycles.
      add(1, 1, 8'h00, 0, 0, 0, 0, 0);
      for (int i = 0; i < 10; i++) add(0, 1, 8'h00, 0, 0, 0, 0, 0);
      // Single device on then off.
      add(0, 1, 8'h08, 1, 1, 3, 0, -1);
      add(0, 1, 8'h08, 0, 0, 3, 0, 1);
      add(0, 1, 8'h00, 1, 0, 3, 0, -1);
      add(0, 1, 8'h00, 0, 0, 3, 0, 0);
      // Restart from ptr=0, all devices on at once.
      add(1, 1, 8'h00, 0, 0, 0, 0, 0);
      for (int i = 0; i < 8; i++) add(0, 1, 8'hFF, 1, 1, 3'(i), (i < 7), -1);
      add(0, 1, 8'hFF, 0, 0, 7, 0, 8);
      // Grant dev 6 (ptr -> 7), then devs 1 and 7 together: 7 first.
      add(0, 1, 8'hBF, 1, 0, 6, 0, -1);
      add(0, 1, 8'h3D, 1, 0, 7, 1, -1);
      add(0, 1, 8'h3D, 1, 0, 1, 0, -1);
      add(0, 1, 8'h3D, 0, 0, 1, 0, 5);
      // All off from ptr=2: 2,3,4,5 then wrap to 0.
      add(0, 1, 8'h00, 1, 0, 2, 1, -1);
      add(0, 1, 8'h00, 1, 0, 3, 1, -1);
      add(0, 1, 8'h00, 1, 0, 4, 1, -1);
      add(0, 1, 8'h00, 1, 0, 5, 1, -1);
      add(0, 1, 8'h00, 1, 0, 0, 0, -1);
      // enable=0: toggle-back clears pending with no event.
      add(0, 0, 8'h04, 0, 0, 0, 1, 0);
      add(0, 0, 8'h04, 0, 0, 0, 1, 0);
      add(0, 0, 8'h00, 0, 0, 0, 0, 0);
      add(0, 1, 8'h00, 0, 0, 0, 0, 0);
      // enable=0 holds the event until enable returns.
      add(0, 0, 8'h04, 0, 0, 0, 1, 0);
      add(0, 1, 8'h04, 1, 1, 2, 0, 0);
      add(0, 1, 8'h04, 0, 0, 2, 0, 1);
      // Reset mid-burst: ptr=3, dev 2 already reported.
      add(0, 1, 8'hFF, 1, 1, 3, 1, -1);
      add(0, 1, 8'hFF, 1, 1, 4, 1, -1);
      add(0, 1, 8'hFF, 1, 1, 5, 1, -1);
      add(1, 1, 8'hFF, 0, 0, 0, 1, 0);
      add(1, 1, 8'hFF, 0, 0, 0, 1, 0);
      for (int i = 0; i < 8; i++) add(0, 1, 8'hFF, 1, 1, 3'(i), (i < 7), -1);
      add(0, 1, 8'hFF, 0, 0, 7, 0, 8);

      foreach (vq[k]) apply(k, vq[k]);

      // Reset is asynchronous: it clears outputs without waiting for an edge.
      @(negedge clk);
      dev_status = 8'h7F;
      @(posedge clk);
      #1;
      chk("pre_async change", int'(change), 1);
      chk("pre_async dev_id", int'(dev_id), 7);
      #2;
      rst = 1'b1;
      #1;
      chk("async change", int'(change), 0);
      chk("async dev_id", int'(dev_id), 0);
      chk("async busy", int'(busy), 1);
      chk("async monitor", mon_cnt, 0);
      @(negedge clk);
      rst        = 1'b0;
      dev_status = 8'h00;
      #1;
      chk("post_async busy", int'(busy), 0);
      repeat (2) @(posedge clk);
      #1;
      chk("post_async change", int'(change), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/device_event_encoder.md
Name: device_event_encoder

Overview:
- Source side of the active-device monitor interface.
- Watches a vector of per-device on/off status lines and emits the `change`/`on_off` event stream that the active-device counter consumes.
- Emits at most one event per clock cycle. Simultaneous status changes are serialised with a round-robin arbiter.
- Invariant: the monitor's count always converges to the number of devices currently on.

Parameters:
- N_DEV, 8, number of monitored devices (2..64).
- ID_W, $clog2(N_DEV), width of the device index output.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset; asynchronous, active-high.
- enable  input  1  1 = events may be issued; 0 = hold, issue nothing.
- dev_status  input  N_DEV  current on(1)/off(0) state per device. Synchronous to clk; synchronised upstream.
- change  output  1  one-cycle event strobe to the monitor.
- on_off  output  1  event direction, valid when change=1: 1 = device turned on, 0 = turned off.
- dev_id  output  ID_W  index of the device the event refers to; valid when change=1.
- busy  output  1  at least one device has an unreported state difference.

Behaviour:
- State:
  - reported[N_DEV-1:0]: the last state told to the monitor, per device.
  - ptr[ID_W-1:0]: round-robin start index.
- Reset (async assert, sync release):
  - reported=0, ptr=0.
  - change=0, on_off=0, dev_id=0.
  - busy reflects dev_status^0 combinationally.
- pending = dev_status ^ reported (combinational). busy = |pending (combinational).
- Grant: the first index i with pending[i]=1, searching ptr, ptr+1, …, N_DEV-1, 0, …, ptr-1.
- At each rising edge with enable=1 and busy=1:
  - change<=1, on_off<=dev_status[i], dev_id<=i.
  - reported[i]<=dev_status[i].
  - ptr<=(i+1) mod N_DEV. N_DEV need not be a power of 2; wrap explicitly.
- Otherwise:
  - change<=0, on_off<=0.
  - dev_id holds its value.
  - reported and ptr hold.
- Latency: a status change present before edge e produces change=1 in the cycle after edge e when uncontended. With k devices pending, all are reported within k consecutive cycles.
- change is never high for two cycles for the same device unless its status toggled again in between.
- Toggle-back: if a device returns to its reported value before being granted, its pending bit clears and no event is issued. The net count stays correct.
- Devices already on when rst releases produce "on" events, matching the monitor resetting to 0.
- Reset mid-burst: all pending reporting is abandoned. After release, arbitration restarts at ptr=0 against reported=0.
- enable=0: events are held, not dropped. Pending differences persist until enable=1.
- All outputs are registered except busy.

Decomposition:
- Shared package (monitor_pkg):
  - N_DEV default.
  - ID_W derivation function.
  - Event encoding constants EV_ON=1, EV_OFF=0.
- One sub-module, rr_arbiter:
  - Parameterised by N_DEV.
  - Inputs: req[N_DEV], ptr.
  - Outputs: gnt_valid, gnt_idx.
  - Purely combinational, reused by later multi-source monitors.
- The top level holds the reported/ptr/output registers.

Test Plan:
- rst=1 with dev_status=8'h00, then release → change=0, on_off=0, dev_id=0, busy=0 for 10 cycles.
- dev_status 8'h00→8'h08, enable=1 → exactly one cycle of change=1, on_off=1, dev_id=3; busy=0 afterwards. Then 8'h08→8'h00 → one pulse with on_off=0, dev_id=3.
- dev_status 8'h00→8'hFF in one cycle → 8 consecutive change pulses, dev_id 0,1,…,7, all on_off=1. A connected monitor reads 8.
- Round-robin: after a grant to dev 6 (ptr=7), set pending on devs 1 and 7 simultaneously → dev_id=7 first, then dev_id=1.
- enable=0: dev 2 goes 0→1 → no event, busy=1. dev 2 goes back 1→0 → busy=0. enable=1 → no event issued.
- Reset mid-burst: apply 8'hFF, assert rst after 3 pulses, release with 8'hFF held → 8 pulses dev_id 0..7. Monitor (also reset) reads 8.
